// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data-memory port: word-organised RAM
// with a fixed access latency, per-byte write lanes and a registered read word.
module data_mem_responder #(
  parameter int unsigned DP_WIDTH  = 32,
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DP_WIDTH-1:0] Address,
  input  logic [DP_WIDTH-1:0] DataIn,
  input  logic                ReadEnable,
  input  logic [3:0]          WriteEnable,
  output logic [DP_WIDTH-1:0] DataOut,
  output logic                MemReady
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned LANES = DP_WIDTH / 8;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state, state_next;

  logic [DP_WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_BITS-1:0] idx_q;
  logic [DP_WIDTH-1:0]  data_q;
  logic [LANES-1:0]     we_q;
  logic                 is_write_q;
  logic [CNT_W-1:0]     cnt;
  logic                 accept_c;
  logic                 done_c;

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^{Address[DP_WIDTH-1:ADDR_BITS+2], Address[1:0]};

  // Busy flag follows the state register directly.
  assign MemReady = (state == BUSY);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept a request in IDLE, complete when the counter expires.
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE: begin
        if (ReadEnable || (WriteEnable != 4'b0000)) begin
          accept_c   = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(0)) begin
          done_c     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, latency counter and registered read word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q      <= '0;
      data_q     <= '0;
      we_q       <= '0;
      is_write_q <= 1'b0;
      cnt        <= '0;
      DataOut    <= '0;
    end else begin
      if (accept_c) begin
        idx_q      <= Address[ADDR_BITS+1:2];
        data_q     <= DataIn;
        we_q       <= WriteEnable;
        is_write_q <= (WriteEnable != 4'b0000);
        cnt        <= CNT_W'(LATENCY - 1);
      end else if ((state == BUSY) && (cnt != CNT_W'(0))) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (done_c && !is_write_q) begin
        DataOut <= mem[idx_q];
      end
    end
  end

  // RAM byte-lane write on the completing edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (done_c && is_write_q) begin
      for (int k = 0; k < LANES; k++) begin
        if (we_q[k]) begin
          mem[idx_q][8*k +: 8] <= data_q[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances at latencies 2, 1 and 5
// share address/data/reset; each has its own request strobes.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic        re2, re1, re5;
  logic [3:0]  we2, we1, we5;
  logic [31:0] dout2, dout1, dout5;
  logic        rdy2, rdy1, rdy5;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DP_WIDTH(32), .ADDR_BITS(10), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .Address(Address), .DataIn(DataIn),
    .ReadEnable(re2), .WriteEnable(we2), .DataOut(dout2), .MemReady(rdy2));

  data_mem_responder #(.DP_WIDTH(32), .ADDR_BITS(10), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .Address(Address), .DataIn(DataIn),
    .ReadEnable(re1), .WriteEnable(we1), .DataOut(dout1), .MemReady(rdy1));

  data_mem_responder #(.DP_WIDTH(32), .ADDR_BITS(10), .LATENCY(5)) u_l5 (
    .clk(clk), .rst(rst), .Address(Address), .DataIn(DataIn),
    .ReadEnable(re5), .WriteEnable(we5), .DataOut(dout5), .MemReady(rdy5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ready_of(input int sel);
    if (sel == 1) return rdy1;
    if (sel == 5) return rdy5;
    return rdy2;
  endfunction

  task automatic set_req(input int sel, input logic re, input logic [3:0] we);
    if (sel == 1) begin re1 = re; we1 = we; end
    else if (sel == 5) begin re5 = re; we5 = we; end
    else begin re2 = re; we2 = we; end
  endtask

  // Called at a negedge; presents a request for one edge, returns at the
  // first negedge with MemReady low and reports the busy pulse width.
  task automatic access(input int sel, input logic re, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] data,
                        output int width);
    Address = addr;
    DataIn  = data;
    set_req(sel, re, we);
    @(negedge clk);
    set_req(sel, 1'b0, 4'b0000);
    width = 0;
    while (ready_of(sel) && width < 40) begin
      width++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    Address = '0; DataIn = '0;
    re2 = 0; re1 = 0; re5 = 0; we2 = '0; we1 = '0; we5 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdy2, rdy1, rdy5} !== 3'b000) begin
      errors++; $display("FAIL reset_ready: got %b expected 000", {rdy2, rdy1, rdy5});
    end
    checks++;
    if (dout2 !== 32'h0 || dout1 !== 32'h0 || dout5 !== 32'h0) begin
      errors++; $display("FAIL reset_dataout: got %h %h %h expected 0", dout2, dout1, dout5);
    end
  endtask

  task automatic test_word_rw();
    int w;
    access(2, 1'b0, 4'b1111, 32'h10, 32'hDEADBEEF, w);
    checks++;
    if (w !== 2) begin errors++; $display("FAIL word_write_width: got %0d expected 2", w); end
    checks++;
    if (dout2 !== 32'h0) begin errors++; $display("FAIL write_keeps_dataout: got %h expected 00000000", dout2); end
    access(2, 1'b1, 4'b0000, 32'h10, 32'h0, w);
    checks++;
    if (w !== 2) begin errors++; $display("FAIL word_read_width: got %0d expected 2", w); end
    checks++;
    if (dout2 !== 32'hDEADBEEF) begin errors++; $display("FAIL word_read_data: got %h expected deadbeef", dout2); end
  endtask

  task automatic test_byte_write();
    int w;
    access(2, 1'b0, 4'b1111, 32'h10, 32'h11223344, w);
    access(2, 1'b0, 4'b0100, 32'h12, 32'h5A5A5A5A, w);
    access(2, 1'b1, 4'b0000, 32'h12, 32'h0, w);
    checks++;
    if (dout2 !== 32'h115A3344) begin errors++; $display("FAIL byte_write: got %h expected 115a3344", dout2); end
  endtask

  task automatic test_halfword_alias();
    int w;
    access(2, 1'b0, 4'b1111, 32'h20, 32'hFFFFFFFF, w);
    access(2, 1'b0, 4'b0011, 32'h20, 32'hBEEFBEEF, w);
    access(2, 1'b1, 4'b0000, 32'h20, 32'h0, w);
    checks++;
    if (dout2 !== 32'hFFFFBEEF) begin errors++; $display("FAIL halfword_write: got %h expected ffffbeef", dout2); end
    access(2, 1'b0, 4'b1111, 32'h0, 32'h0, w);  // unrelated write, DataOut must hold
    access(2, 1'b1, 4'b0000, 32'h20 + 32'h1000, 32'h0, w);
    checks++;
    if (dout2 !== 32'hFFFFBEEF) begin errors++; $display("FAIL alias_read: got %h expected ffffbeef", dout2); end
  endtask

  task automatic test_rw_collision_back_to_back();
    int w;
    access(2, 1'b0, 4'b1111, 32'h40, 32'h12345678, w);
    access(2, 1'b1, 4'b1000, 32'h40, 32'hAB000000, w);
    checks++;
    if (dout2 !== 32'hFFFFBEEF) begin errors++; $display("FAIL collision_dataout: got %h expected ffffbeef", dout2); end
    // Called in the first IDLE cycle: must be accepted at this cycle's edge.
    access(2, 1'b1, 4'b0000, 32'h40, 32'h0, w);
    checks++;
    if (w !== 2) begin errors++; $display("FAIL back_to_back_width: got %0d expected 2", w); end
    checks++;
    if (dout2 !== 32'hAB345678) begin errors++; $display("FAIL collision_write: got %h expected ab345678", dout2); end
  endtask

  task automatic test_latency();
    int w;
    access(1, 1'b0, 4'b1111, 32'h50, 32'hCAFEF00D, w);
    checks++;
    if (w !== 1) begin errors++; $display("FAIL lat1_write_width: got %0d expected 1", w); end
    access(1, 1'b1, 4'b0000, 32'h50, 32'h0, w);
    checks++;
    if (w !== 1) begin errors++; $display("FAIL lat1_read_width: got %0d expected 1", w); end
    checks++;
    if (dout1 !== 32'hCAFEF00D) begin errors++; $display("FAIL lat1_read_data: got %h expected cafef00d", dout1); end
    access(5, 1'b0, 4'b1111, 32'h50, 32'h0BADCAFE, w);
    checks++;
    if (w !== 5) begin errors++; $display("FAIL lat5_write_width: got %0d expected 5", w); end
    Address = 32'h50;
    set_req(5, 1'b1, 4'b0000);
    @(negedge clk);
    set_req(5, 1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rdy5 !== 1'b1 || dout5 !== 32'h0) begin
        errors++; $display("FAIL lat5_busy_cycle%0d: got ready=%b data=%h expected ready=1 data=00000000", i, rdy5, dout5);
      end
      @(negedge clk);
    end
    checks++;
    if (rdy5 !== 1'b0 || dout5 !== 32'h0BADCAFE) begin
      errors++; $display("FAIL lat5_complete: got ready=%b data=%h expected ready=0 data=0badcafe", rdy5, dout5);
    end
  endtask

  task automatic test_reset_mid_access();
    int w;
    access(2, 1'b0, 4'b1111, 32'h30, 32'h0, w);
    access(2, 1'b1, 4'b0000, 32'h40, 32'h0, w);  // DataOut nonzero before the abort
    Address = 32'h30;
    DataIn  = 32'hFFFFFFFF;
    set_req(2, 1'b0, 4'b1111);
    @(negedge clk);
    set_req(2, 1'b0, 4'b0000);
    checks++;
    if (rdy2 !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b expected 1", rdy2); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (rdy2 !== 1'b0 || dout2 !== 32'h0) begin
      errors++; $display("FAIL abort_outputs: got ready=%b data=%h expected ready=0 data=00000000", rdy2, dout2);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    access(2, 1'b1, 4'b0000, 32'h30, 32'h0, w);
    checks++;
    if (dout2 !== 32'h0) begin errors++; $display("FAIL abort_no_write: got %h expected 00000000", dout2); end
    access(2, 1'b1, 4'b0000, 32'h12, 32'h0, w);
    checks++;
    if (dout2 !== 32'h115A3344) begin errors++; $display("FAIL ram_survives_reset: got %h expected 115a3344", dout2); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_write();
    test_halfword_alias();
    test_rw_collision_back_to_back();
    test_latency();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU data-memory port.
- Accepts the read strobe, the per-byte write-enable lanes, the address and the lane-replicated write data driven by the CPU-side memory controller.
- Models a word-organised RAM with a parameterised access latency.
- Drives the busy/ready indication (1 = busy, 0 = ready) and the registered read word that the controller consumes.

Parameters:
DP_WIDTH, 32, data and address width (fixed at 32; byte-lane logic assumes 4 lanes)
ADDR_BITS, 10, log2 of RAM depth in words (default 1024 words = 4 KiB)
LATENCY, 2, number of cycles MemReady is held high per access; legal range 1..15

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
Address  input  32  byte address from controller; word index = Address[ADDR_BITS+1:2], all other bits ignored (aliasing)
DataIn  input  32  write data, already lane-replicated by controller
ReadEnable  input  1  read request
WriteEnable  input  4  per-byte write lanes; bit3 = bits[31:24] … bit0 = bits[7:0]
DataOut  output  32  registered read word
MemReady  output  1  busy flag: 1 = access in progress, 0 = idle/ready

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, counter=0, MemReady=0, DataOut=32'h0.
  - RAM contents are not cleared.
  - Reset asserted mid-access aborts it: no RAM write, DataOut stays 0.
- States:
  - IDLE:
    - MemReady=0.
    - At a rising edge with ReadEnable=1 or WriteEnable!=0: capture word index, DataIn, WriteEnable and op type; load counter=LATENCY-1; go to BUSY.
  - BUSY:
    - MemReady=1 combinationally from state; request inputs are ignored.
    - Each edge with counter!=0 decrements counter.
    - At the edge with counter==0: perform the captured operation and go to IDLE.
- Timing:
  - MemReady is high for exactly LATENCY cycles, starting the cycle after the request is first sampled.
  - LATENCY>=1 is mandatory: the controller must see MemReady=1 while its request is still asserted in order to latch its mask.
- Read: on the completing edge, DataOut <= RAM[idx]. DataOut is valid from the first IDLE cycle and holds until the next completed read.
- Write:
  - On the completing edge, each RAM byte lane k is written with DataIn lane k only where captured WriteEnable[k]=1; other lanes are unchanged.
  - DataOut is unchanged.
- Simultaneous ReadEnable=1 and WriteEnable!=0: treat as a write only. Read is dropped and DataOut is unchanged.
- Back-to-back: a new request present in the first IDLE cycle after completion is accepted at that cycle's edge. No dead cycle is required beyond that IDLE cycle.
- Bytes/halfwords:
  - The responder performs no alignment or extension; it always returns the full word.
  - The controller selects lanes and extends.
- Out-of-range addresses alias modulo 2^ADDR_BITS words; no error is signalled.
- Sampling: inputs are sampled only at rising edges in IDLE. Glitches while BUSY have no effect.

Test Plan:
- Reset, then write WE=4'b1111, Addr=0x10, DataIn=0xDEADBEEF; then read Addr=0x10 -> MemReady high exactly 2 cycles for each access; DataOut=0xDEADBEEF on the first IDLE cycle after the read.
- Byte write WE=4'b0100, Addr=0x12, DataIn=0x5A5A5A5A over a word preset to 0x11223344; read back -> DataOut=0x115A3344.
- Halfword write WE=4'b0011, Addr=0x20, DataIn=0xBEEFBEEF over 0xFFFFFFFF; read -> 0xFFFFBEEF; read of Addr=0x20+4*1024 (alias) returns the same value.
- Rebuild with LATENCY=1 and LATENCY=5 -> MemReady pulse width is 1 and 5 cycles respectively; DataOut updates on the completing edge only.
- Assert rst=0 asynchronously mid-BUSY of a write to Addr=0x30 (word preset 0x0) -> MemReady and DataOut drop to 0 immediately; later read of 0x30 returns 0x00000000.
- ReadEnable=1 with WE=4'b1000, Addr=0x40, DataIn=0xAB000000 -> word 0x40 top byte becomes 0xAB and DataOut holds its previous value. A following back-to-back read presented in the first IDLE cycle is accepted at that edge.
